// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: arbitrates an instruction-fetch port and a data port onto a
// single-ported memory. Each access is a fixed IDLE -> ACCESS -> RESP walk;
// contention is resolved round-robin, and every output comes from a register.
module mem_port_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [11:0] if_addr,
  output logic        if_ack,
  output logic [15:0] ir_out,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [11:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] mdr_out,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic [15:0] acc_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        lastGrantData_q, lastGrantData_d;
  logic        grantData_q, grantData_d;
  logic        memWe_q, memWe_d;
  logic [11:0] memAddr_q, memAddr_d;
  logic [15:0] memWdata_q, memWdata_d;
  logic [15:0] irOut_q, irOut_d;
  logic [15:0] mdrOut_q, mdrOut_d;
  logic [15:0] accCount_q, accCount_d;
  logic        ifAck_q, ifAck_d;
  logic        dAck_q, dAck_d;
  logic        busy_q, busy_d;
  logic        pickData;

  // Next-state logic: arbitrate in IDLE, capture read data when ACCESS closes, pulse ack in RESP
  always_comb begin
    state_d         = state_q;
    lastGrantData_d = lastGrantData_q;
    grantData_d     = grantData_q;
    memWe_d         = 1'b0;
    memAddr_d       = memAddr_q;
    memWdata_d      = memWdata_q;
    irOut_d         = irOut_q;
    mdrOut_d        = mdrOut_q;
    accCount_d      = accCount_q;
    ifAck_d         = 1'b0;
    dAck_d          = 1'b0;
    pickData        = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Data wins when alone, or when both ask and fetch was granted last
          pickData        = d_req && (!if_req || !lastGrantData_q);
          grantData_d     = pickData;
          lastGrantData_d = pickData;
          memAddr_d       = pickData ? d_addr : if_addr;
          memWe_d         = pickData && d_we;
          if (pickData) begin
            memWdata_d = d_wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!grantData_q) begin
          irOut_d = mem_rdata;
        end else if (!memWe_q) begin
          mdrOut_d = mem_rdata;
        end
        if (accCount_q != 16'hFFFF) begin
          accCount_d = accCount_q + 16'd1;
        end
        ifAck_d = !grantData_q;
        dAck_d  = grantData_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; synchronous reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      lastGrantData_q <= 1'b0;
      grantData_q     <= 1'b0;
      memWe_q         <= 1'b0;
      memAddr_q       <= 12'h000;
      memWdata_q      <= 16'h0000;
      irOut_q         <= 16'h0000;
      mdrOut_q        <= 16'h0000;
      accCount_q      <= 16'h0000;
      ifAck_q         <= 1'b0;
      dAck_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      lastGrantData_q <= lastGrantData_d;
      grantData_q     <= grantData_d;
      memWe_q         <= memWe_d;
      memAddr_q       <= memAddr_d;
      memWdata_q      <= memWdata_d;
      irOut_q         <= irOut_d;
      mdrOut_q        <= mdrOut_d;
      accCount_q      <= accCount_d;
      ifAck_q         <= ifAck_d;
      dAck_q          <= dAck_d;
      busy_q          <= busy_d;
    end
  end

  assign if_ack    = ifAck_q;
  assign d_ack     = dAck_q;
  assign ir_out    = irOut_q;
  assign mdr_out   = mdrOut_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign busy      = busy_q;
  assign acc_count = accCount_q;

endmodule
